// File: rtl/mem_lsu_pkg.sv
// Shared types and encodings for the memory stage: bus widths, memory
// operation and access-size codes, fault codes and the FSM state type.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_t;

  // Access size / signedness, taken from the instruction funct3 field.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    EXC_ILLEGAL  = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_BUSERR   = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_code_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the memory stage (master) and memory (slave).
// A request is open while dbus_req_o is high; every master output stays
// stable until the slave returns dbus_ack_i for exactly one cycle, with
// dbus_err_i and dbus_rdata_i meaningful only in that ack cycle.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic               dbus_req_o;
  logic               dbus_we_o;
  logic [RegBus-1:0]  dbus_addr_o;
  logic [3:0]         dbus_sel_o;
  logic [RegBus-1:0]  dbus_wdata_o;
  logic               dbus_ack_i;
  logic               dbus_err_i;
  logic [RegBus-1:0]  dbus_rdata_i;

  modport master (
    output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
    input  dbus_ack_i, dbus_err_i, dbus_rdata_i
  );

  modport slave (
    input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
    output dbus_ack_i, dbus_err_i, dbus_rdata_i
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane logic for the memory stage. The request side turns funct3 and
// the low address bits into lane enables, replicated store data and the
// legality/alignment flags; the response side extracts and extends the
// addressed lanes of returned read data.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_addr_lo,
  input  logic [RegBus-1:0] i_st_data,
  output logic [3:0]        o_sel,
  output logic [RegBus-1:0] o_st_data,
  output logic              o_illegal,
  output logic              o_misaligned,
  input  logic [2:0]        i_ld_funct3,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [RegBus-1:0] i_ld_rdata,
  output logic [RegBus-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request side: lane enables, store replication, legality and alignment.
  always_comb begin
    o_sel        = 4'b0000;
    o_st_data    = '0;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_sel     = 4'b0001 << i_addr_lo;
        o_st_data = {4{i_st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_sel        = 4'b0011 << i_addr_lo;
        o_st_data    = {2{i_st_data[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      F3_W: begin
        o_sel        = 4'b1111;
        o_st_data    = i_st_data;
        o_misaligned = |i_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  // Response side: pick the addressed byte/half and sign- or zero-extend.
  always_comb begin
    w_byte    = i_ld_rdata[{i_ld_addr_lo, 3'b000} +: 8];
    w_half    = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage. ALU results pass through one register stage; legal loads
// and stores run a single req/ack transaction on the data bus while the
// pipeline is held through stallreq_o. Faults (illegal size, misalignment,
// bus error, bus timeout) are reported with the writeback pulse.
//
// Handshake: valid_i is taken on a rising edge only when ready_o is high
// (state IDLE) and flush_i is low; an offered result is never stored while
// ready_o is low, so upstream must keep it until the stall drops.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [RegBus-1:0] RESET_ADDR     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [RegAddrBus-1:0] wreg_i,
  input  logic                  wd_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [1:0]            mem_op_i,
  input  logic [2:0]            mem_funct3_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     mem_wdata_i,
  input  logic                  flush_i,
  output logic                  stallreq_o,
  mem_lsu_if.master             dbus,
  output logic                  wb_valid_o,
  output logic [RegAddrBus-1:0] wreg_o,
  output logic                  wd_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  exc_o,
  output logic [1:0]            exc_code_o,
  output state_t                dbg_state_o
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_state_next;

  // Bus-side registers.
  logic              r_req;
  logic              r_we;
  logic [RegBus-1:0] r_addr;
  logic [3:0]        r_sel;
  logic [RegBus-1:0] r_bus_wdata;
  logic [7:0]        r_cnt;

  // Instruction fields captured for the outstanding access.
  logic [RegAddrBus-1:0] r_c_wreg;
  logic                  r_c_wd;
  logic                  r_c_load;
  logic [2:0]            r_c_funct3;
  logic [1:0]            r_c_addr_lo;
  logic                  r_discard;

  // Writeback registers.
  logic                  r_wb_valid;
  logic [RegAddrBus-1:0] r_wreg;
  logic                  r_wd;
  logic [RegBus-1:0]     r_wdata;
  logic                  r_exc;
  exc_code_t             r_exc_code;

  logic              w_is_mem;
  logic              w_accept;
  logic              w_issue;
  logic              w_fault_imm;
  logic              w_complete;
  logic              w_timeout;
  logic              w_kill;
  logic [3:0]        w_sel;
  logic [RegBus-1:0] w_st_data;
  logic [RegBus-1:0] w_ld_data;
  logic              w_illegal;
  logic              w_misaligned;

  lsu_align u_align (
    .i_funct3     (mem_funct3_i),
    .i_addr_lo    (mem_addr_i[1:0]),
    .i_st_data    (mem_wdata_i),
    .o_sel        (w_sel),
    .o_st_data    (w_st_data),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned),
    .i_ld_funct3  (r_c_funct3),
    .i_ld_addr_lo (r_c_addr_lo),
    .i_ld_rdata   (dbus.dbus_rdata_i),
    .o_ld_data    (w_ld_data)
  );

  assign w_is_mem = (mem_op_i == MEM_LOAD) || (mem_op_i == MEM_STORE);
  assign w_kill   = r_discard | flush_i;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state and per-cycle decisions: accept, issue, fault, finish.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_fault_imm  = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          w_accept = 1'b1;
          if (w_is_mem) begin
            if (w_illegal || w_misaligned) begin
              w_fault_imm = 1'b1;
            end else begin
              w_issue      = 1'b1;
              w_state_next = ST_WAIT_ACK;
            end
          end
        end
      end
      ST_WAIT_ACK: begin
        if (dbus.dbus_ack_i) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_cnt == CntLast) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Bus request, captured fields, timeout counter and writeback results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= RESET_ADDR;
      r_sel       <= 4'b0000;
      r_bus_wdata <= '0;
      r_cnt       <= 8'd0;
      r_c_wreg    <= '0;
      r_c_wd      <= 1'b0;
      r_c_load    <= 1'b0;
      r_c_funct3  <= 3'b000;
      r_c_addr_lo <= 2'b00;
      r_discard   <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wreg      <= '0;
      r_wd        <= 1'b0;
      r_wdata     <= '0;
      r_exc       <= 1'b0;
      r_exc_code  <= EXC_ILLEGAL;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc      <= 1'b0;

      if (w_issue) begin
        r_req       <= 1'b1;
        r_we        <= (mem_op_i == MEM_STORE);
        r_addr      <= {mem_addr_i[RegBus-1:2], 2'b00};
        r_sel       <= w_sel;
        r_bus_wdata <= w_st_data;
        r_cnt       <= 8'd0;
        r_c_wreg    <= wreg_i;
        r_c_wd      <= wd_i;
        r_c_load    <= (mem_op_i == MEM_LOAD);
        r_c_funct3  <= mem_funct3_i;
        r_c_addr_lo <= mem_addr_i[1:0];
        r_discard   <= 1'b0;
      end else if (w_fault_imm) begin
        r_wb_valid <= 1'b1;
        r_exc      <= 1'b1;
        r_exc_code <= w_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
        r_wreg     <= wreg_i;
        r_wd       <= 1'b0;
        r_wdata    <= mem_addr_i;
      end else if (w_accept) begin
        r_wb_valid <= 1'b1;
        r_wreg     <= wreg_i;
        r_wd       <= wd_i & (wreg_i != '0);
        r_wdata    <= wdata_i;
      end

      if (r_state == ST_WAIT_ACK) begin
        r_cnt <= r_cnt + 8'd1;
        if (flush_i) r_discard <= 1'b1;
        if (w_complete || w_timeout) begin
          r_req       <= 1'b0;
          r_we        <= 1'b0;
          r_addr      <= RESET_ADDR;
          r_sel       <= 4'b0000;
          r_bus_wdata <= '0;
          r_discard   <= 1'b0;
          if (!w_kill) begin
            r_wb_valid <= 1'b1;
            r_wreg     <= r_c_wreg;
            r_wd       <= 1'b0;
            if (w_timeout) begin
              r_exc      <= 1'b1;
              r_exc_code <= EXC_TIMEOUT;
              r_wdata    <= r_addr;
            end else if (dbus.dbus_err_i) begin
              r_exc      <= 1'b1;
              r_exc_code <= EXC_BUSERR;
              r_wdata    <= r_addr;
            end else if (r_c_load) begin
              r_wdata <= w_ld_data;
              r_wd    <= r_c_wd & (r_c_wreg != '0);
            end else begin
              r_wdata <= r_addr;
            end
          end
        end
      end
    end
  end

  assign ready_o           = (r_state == ST_IDLE);
  assign stallreq_o        = (r_state == ST_WAIT_ACK);
  assign dbg_state_o       = r_state;
  assign dbus.dbus_req_o   = r_req;
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = r_addr;
  assign dbus.dbus_sel_o   = r_sel;
  assign dbus.dbus_wdata_o = r_bus_wdata;
  assign wb_valid_o        = r_wb_valid;
  assign wreg_o            = r_wreg;
  assign wd_o              = r_wd;
  assign wdata_o           = r_wdata;
  assign exc_o             = r_exc;
  assign exc_code_o        = r_exc_code;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases followed by random operations, with a
// behavioural model of the memory stage producing expected writebacks.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int          TO       = 4;
  localparam logic [31:0] RST_ADDR = 32'hCAFE_0000;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  wreg_i;
  logic        wd_i;
  logic [31:0] wdata_i;
  logic [1:0]  mem_op_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        wb_valid_o;
  logic [4:0]  wreg_o;
  logic        wd_o;
  logic [31:0] wdata_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;
  state_t      dbg_state;

  mem_lsu_if bus_if();

  mem_lsu #(.TIMEOUT_CYCLES(TO), .RESET_ADDR(RST_ADDR)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .wreg_i       (wreg_i),
    .wd_i         (wd_i),
    .wdata_i      (wdata_i),
    .mem_op_i     (mem_op_i),
    .mem_funct3_i (mem_funct3_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .flush_i      (flush_i),
    .stallreq_o   (stallreq_o),
    .dbus         (bus_if.master),
    .wb_valid_o   (wb_valid_o),
    .wreg_o       (wreg_o),
    .wd_o         (wd_o),
    .wdata_o      (wdata_o),
    .exc_o        (exc_o),
    .exc_code_o   (exc_code_o),
    .dbg_state_o  (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected writebacks: {data_checked, exc, code, wd, wreg, wdata}.
  logic [41:0] exp_q[$];

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Access size in bytes for a funct3 value, 0 when the code is illegal.
  function automatic int width_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Behavioural model of what writeback should show for one instruction.
  function automatic logic [41:0] model(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [4:0] wreg,
                                        input logic wd, input logic [31:0] alu,
                                        input logic [31:0] rdata, input logic err,
                                        input bit tmo);
    int          w;
    int          off;
    logic [31:0] v;
    logic        wd_eff;
    wd_eff = wd && (wreg != 5'd0);
    if (op == 2'b00 || op == 2'b11) return {1'b1, 1'b0, 2'b00, wd_eff, wreg, alu};
    w   = width_of(f3);
    off = int'(addr[1:0]);
    if (w == 0)       return {1'b0, 1'b1, 2'b00, 1'b0, wreg, 32'h0};
    if (off % w != 0) return {1'b0, 1'b1, 2'b01, 1'b0, wreg, 32'h0};
    if (tmo)          return {1'b0, 1'b1, 2'b11, 1'b0, wreg, 32'h0};
    if (err)          return {1'b0, 1'b1, 2'b10, 1'b0, wreg, 32'h0};
    if (op == 2'b10)  return {1'b0, 1'b0, 2'b00, 1'b0, wreg, 32'h0};
    v = rdata >> (8 * off);
    if (w == 1) begin
      v = v % 256;
      if (f3[2] == 1'b0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2) begin
      v = v % 65536;
      if (f3[2] == 1'b0 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return {1'b1, 1'b0, 2'b00, wd_eff, wreg, v};
  endfunction

  // Scoreboard: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [41:0] e;
    logic [41:0] got;
    if (!rst) begin
      if (exc_o && !wb_valid_o) check("exc_unqualified", exc_o, 1'b0);
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", wb_valid_o, 1'b0);
        end else begin
          e   = exp_q.pop_front();
          got = {e[41], exc_o, (exc_o ? exc_code_o : 2'b00), wd_o, wreg_o,
                 (e[41] ? wdata_o : 32'h0)};
          check("wb_result", got, e);
        end
      end
    end
  end

  task automatic drive_idle();
    valid_i      = 1'b0;
    flush_i      = 1'b0;
    wreg_i       = 5'd0;
    wd_i         = 1'b0;
    wdata_i      = 32'h0;
    mem_op_i     = 2'b00;
    mem_funct3_i = 3'b000;
    mem_addr_i   = 32'h0;
    mem_wdata_i  = 32'h0;
  endtask

  // One instruction through the stage, acting as bus slave when needed.
  // lat = wait cycle carrying ack (0 = never), flush_at = wait cycle of flush.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wreg, input logic wd,
                        input logic [31:0] alu, input logic [31:0] rdata, input int lat,
                        input logic err, input int flush_at);
    int          w;
    int          off;
    bit          bus;
    logic [3:0]  esel;
    logic [31:0] esd;
    w    = width_of(f3);
    off  = int'(addr[1:0]);
    bus  = (op == 2'b01 || op == 2'b10) && (w != 0) && (off % w == 0);
    esel = (w == 4) ? 4'hF : ((w == 2) ? 4'h3 : 4'h1);
    if (w != 4) esel = esel << off;
    if (w == 1)      esd = (sdata & 32'hFF) * 32'h0101_0101;
    else if (w == 2) esd = (sdata & 32'hFFFF) * 32'h0001_0001;
    else             esd = sdata;
    if (!(bus && flush_at != 0))
      exp_q.push_back(model(op, f3, addr, wreg, wd, alu, rdata, err, (lat == 0)));

    @(negedge clk);
    check("ready_idle", ready_o, 1'b1);
    valid_i      = 1'b1;
    mem_op_i     = op;
    mem_funct3_i = f3;
    mem_addr_i   = addr;
    mem_wdata_i  = sdata;
    wreg_i       = wreg;
    wd_i         = wd;
    wdata_i      = alu;
    @(negedge clk);
    drive_idle();

    if (bus) begin
      check("bus_we", bus_if.dbus_we_o, (op == 2'b10));
      check("bus_sel", bus_if.dbus_sel_o, esel);
      check("bus_wdata", bus_if.dbus_wdata_o, esd);
      for (int c = 1; c <= TO; c++) begin
        check("req_held", bus_if.dbus_req_o, 1'b1);
        check("stall_held", stallreq_o, 1'b1);
        check("bus_addr", bus_if.dbus_addr_o, {addr[31:2], 2'b00});
        if (c == flush_at) flush_i = 1'b1;
        if (c == lat) begin
          bus_if.dbus_ack_i   = 1'b1;
          bus_if.dbus_err_i   = err;
          bus_if.dbus_rdata_i = rdata;
        end
        @(negedge clk);
        bus_if.dbus_ack_i   = 1'b0;
        bus_if.dbus_err_i   = 1'b0;
        bus_if.dbus_rdata_i = $urandom;
        flush_i             = 1'b0;
        if (c == lat) break;
      end
      check("req_dropped", bus_if.dbus_req_o, 1'b0);
      check("stall_dropped", stallreq_o, 1'b0);
      check("addr_idle", bus_if.dbus_addr_o, RST_ADDR);
      if (lat == 0) begin
        bus_if.dbus_ack_i   = 1'b1;
        bus_if.dbus_rdata_i = 32'h1111_2222;
        @(negedge clk);
        bus_if.dbus_ack_i = 1'b0;
        check("late_ack_ignored", ready_o, 1'b1);
      end
    end else begin
      check("no_req", bus_if.dbus_req_o, 1'b0);
      check("no_stall", stallreq_o, 1'b0);
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          lat;
    int          fl;
    int          r;
    logic        err;

    rst                 = 1'b1;
    bus_if.dbus_ack_i   = 1'b0;
    bus_if.dbus_err_i   = 1'b0;
    bus_if.dbus_rdata_i = 32'h0;
    drive_idle();
    repeat (3) @(negedge clk);
    check("rst_req", bus_if.dbus_req_o, 1'b0);
    check("rst_addr", bus_if.dbus_addr_o, RST_ADDR);
    check("rst_wb", wb_valid_o, 1'b0);
    check("rst_exc", exc_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // Directed cases.
    run_op(2'b00, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 1, 1'b0, 0);
    run_op(2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h5555, 32'h0, 1, 1'b0, 0);
    run_op(2'b01, 3'd0, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FF_FF00, 3, 1'b0, 0);
    run_op(2'b01, 3'd4, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FF_FF00, 3, 1'b0, 0);
    run_op(2'b10, 3'd1, 32'h2002, 32'hAAAA_BEEF, 5'd3, 1'b1, 32'h0, 32'h0, 2, 1'b0, 0);
    run_op(2'b01, 3'd2, 32'h0006, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0, 1, 1'b0, 0);
    run_op(2'b01, 3'd2, 32'h0100, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0, 2, 1'b1, 0);
    run_op(2'b01, 3'd2, 32'h0200, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0, 0, 1'b0, 0);
    run_op(2'b01, 3'd2, 32'h0300, 32'h0, 5'd9, 1'b1, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 2);
    run_op(2'b01, 3'd3, 32'h0400, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 1, 1'b0, 0);
    run_op(2'b01, 3'd5, 32'h0402, 32'h0, 5'd4, 1'b1, 32'h0, 32'h9876_0000, 4, 1'b0, 0);

    // Flush while idle: nothing accepted, nothing written back.
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; mem_op_i = 2'b01; mem_funct3_i = 3'd2;
    mem_addr_i = 32'h0500; wreg_i = 5'd6; wd_i = 1'b1;
    @(negedge clk);
    drive_idle();
    check("flush_idle_req", bus_if.dbus_req_o, 1'b0);
    check("flush_idle_stall", stallreq_o, 1'b0);
    @(negedge clk);

    // Reset in the middle of a wait abandons the access immediately.
    valid_i = 1'b1; mem_op_i = 2'b01; mem_funct3_i = 3'd2;
    mem_addr_i = 32'h0600; wreg_i = 5'd8; wd_i = 1'b1;
    @(negedge clk);
    drive_idle();
    check("pre_rst_req", bus_if.dbus_req_o, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", bus_if.dbus_req_o, 1'b0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_stall", stallreq_o, 1'b0);
    check("rst_mid_addr", bus_if.dbus_addr_o, RST_ADDR);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random operations.
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      case (r)
        0, 1:    f3 = 3'd0;
        2:       f3 = 3'd1;
        3, 4:    f3 = 3'd2;
        5:       f3 = 3'd4;
        6:       f3 = 3'd5;
        7:       f3 = 3'd3;
        8:       f3 = 3'(6 + $urandom_range(0, 1));
        default: f3 = 3'd2;
      endcase
      addr = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) begin
        if (width_of(f3) == 4)      addr[1:0] = 2'b00;
        else if (width_of(f3) == 2) addr[0]   = 1'b0;
      end
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      err = ($urandom_range(0, 7) == 0);
      fl  = 0;
      if ((op == 2'b01 || op == 2'b10) && width_of(f3) != 0 &&
          (int'(addr[1:0]) % width_of(f3) == 0) && $urandom_range(0, 9) == 0)
        fl = $urandom_range(1, (lat == 0) ? TO : lat);
      run_op(op, f3, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, lat, err, fl);
    end

    repeat (2) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory stage directly downstream of the execute stage; consumes its {wreg, wd, wdata} result plus a load/store request.
- Non-memory results pass through with one register stage.
- Loads/stores run a req/ack transaction on the data bus, with byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout.
- Holds the pipeline through stallreq_o while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in WAIT_ACK without ack before a bus-timeout fault (1..255).
- RESET_ADDR, 32'h0, value of dbus_addr_o at reset and when idle.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; rst is asynchronous, active-high
- valid_i  in  1  execute result valid this cycle
- ready_o  out  1  block accepts valid_i this cycle (state IDLE)
- wreg_i  in  5  destination register address
- wd_i  in  1  register write enable from execute
- wdata_i  in  32  ALU result
- mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- mem_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- mem_addr_i  in  32  effective address
- mem_wdata_i  in  32  store data (rs2)
- flush_i  in  1  discard the in-flight instruction
- stallreq_o  out  1  stall request to pipeline control
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word address, addr[1:0] forced to 00
- dbus_sel_o  out  4  byte-lane enables
- dbus_wdata_o  out  32  lane-steered store data
- dbus_ack_i  in  1  transaction complete
- dbus_err_i  in  1  bus error; valid only with ack
- dbus_rdata_i  in  32  read data; valid with ack
- wb_valid_o  out  1  one-cycle pulse, result valid
- wreg_o  out  5  to writeback
- wd_o  out  1  to writeback
- wdata_o  out  32  to writeback
- exc_o  out  1  fault, qualified by wb_valid_o
- exc_code_o  out  2  01 misaligned, 10 bus error, 11 timeout, 00 illegal funct3

Behaviour:
- Reset values (asynchronous): state IDLE; outputs 0; dbus_addr_o = RESET_ADDR; timeout counter 0.
- FSM states: IDLE, WAIT_ACK.
- ready_o = (state==IDLE); stallreq_o = (state==WAIT_ACK).
- IDLE, valid_i, op none/reserved:
  - Next edge: wb_valid_o=1, wreg_o=wreg_i, wdata_o=wdata_i.
  - wd_o = wd_i & (wreg_i!=0).
  - Latency 1.
- IDLE, valid_i, load/store with illegal funct3 or misaligned address (H with addr[0]; W with addr[1:0]!=0):
  - No bus access.
  - Next edge: wb_valid_o=1, exc_o=1, wd_o=0, with the matching code.
- IDLE, valid_i, legal access:
  - Next edge: dbus_req_o=1; addr, sel, we and wdata latched; counter cleared; go to WAIT_ACK.
  - Instruction fields are captured internally.
  - Lane select: sel = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W).
  - Store data: replicated per width (B: {4{d[7:0]}}; H: {2{d[15:0]}}; W: d).
- WAIT_ACK:
  - All dbus outputs held stable until ack; counter increments each cycle.
  - On ack: req drops on the same edge and state returns to IDLE.
  - Load: lane-extracted and extended data goes to wdata_o; wd_o = captured wd & (wreg!=0).
  - Store: wd_o=0.
  - wb_valid_o pulses on that edge. Ack-to-writeback is therefore 1 cycle; total load latency is 2 + bus wait.
- ack with err: wb_valid_o=1, exc_o=1, code 10, wd_o=0.
- Counter reaching TIMEOUT_CYCLES without ack: req drops; fault pulse with code 11; return to IDLE. A late ack arriving in IDLE is ignored.
- flush_i in IDLE: the input is not accepted and no outputs fire.
- flush_i in WAIT_ACK:
  - The transaction completes on the bus (req cannot be withdrawn).
  - A discard flag is set; on completion wb_valid_o stays 0 and exc_o stays 0.
- wb_valid_o, exc_o: 0 on every edge not listed above.
- rst asserted mid-transaction: req drops immediately (asynchronous); the pending access is abandoned.

Decomposition:
- Shared package/define file: mem_op encodings, funct3 load/store codes, exc_code values, state encoding. Widths reuse RegBus and RegAddrBus.
- One natural sub-module, lsu_align: combinational lane select, store replication, load extract/extend, misalignment check.

Test Plan:
- ALU pass-through: valid_i, op none, wreg=5, wd=1, wdata=32'h1234 -> next cycle wb_valid_o=1, wreg_o=5, wdata_o=32'h1234, stallreq_o never high.
- LB at 32'h1003, ack after 3 cycles with rdata 32'h80FF_FF00:
  - Expect dbus_addr_o=32'h1000, sel=1000, req held 3 cycles, stallreq_o high throughout.
  - wdata_o=32'hFFFF_FF80. LBU variant gives 32'h80.
- SH at 32'h2002, data 32'hAAAA_BEEF -> we=1, sel=1100, dbus_wdata_o=32'hBEEF_BEEF; on ack wb_valid_o=1, wd_o=0.
- LW at 32'h0006 -> no dbus_req_o; next cycle exc_o=1, code 01, wd_o=0.
- Bus faults:
  - Error: ack+err on LW gives exc code 10.
  - Timeout: TIMEOUT_CYCLES=4 with no ack gives code 11 after 4 wait cycles; a later ack is ignored.
- flush_i pulse in WAIT_ACK, then ack -> no wb_valid_o. Separately, rst asserted mid-wait -> dbus_req_o=0 before the next edge, FSM in IDLE.
